// File: rtl/inst_queue_pkg.sv
// Shared types for the instruction queue: queue entry layout and default depth.
package rv32i_types;

    localparam int IQ_DEPTH = 16;

    typedef struct packed {
        logic [63:0] inst;
        logic        branch_pred;
    } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-to-dispatch instruction queue bus; master is the fetch/dispatch side, slave is the queue.
interface inst_queue_if
    import rv32i_types::*;
#(
    parameter int DEPTH = IQ_DEPTH
) ();

    logic                     branch_mispredict;
    logic                     enq_valid;
    logic [63:0]              enq_inst;
    logic                     enq_branch_pred;
    logic                     full;
    logic                     almost_full;
    logic                     deq_ready;
    logic                     deq_valid;
    logic [63:0]              deq_inst;
    logic                     deq_branch_pred;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output branch_mispredict, enq_valid, enq_inst, enq_branch_pred, deq_ready,
        input  full, almost_full, deq_valid, deq_inst, deq_branch_pred, count
    );

    modport slave (
        input  branch_mispredict, enq_valid, enq_inst, enq_branch_pred, deq_ready,
        output full, almost_full, deq_valid, deq_inst, deq_branch_pred, count
    );

endinterface

// File: rtl/inst_queue.sv
// Circular first-word-fall-through instruction queue between fetch and decode/dispatch.
// Define IQ_BYPASS_EN to let an enqueued word reach dispatch in the same cycle when the queue is empty.
module inst_queue
    import rv32i_types::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int AFULL_THR = DEPTH - 2
) (
    input logic         clk,
    input logic         rst,
    inst_queue_if.slave iq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THR);

    iq_entry_t        entries [DEPTH];
    iq_entry_t        head_entry;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             empty;
    logic             write_en;
    logic             pop;
    logic             out_valid;
    logic [63:0]      out_inst;
    logic             out_pred;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign head_entry = entries[head];

    // Full is taken from the registered count only, so a pop never opens room for a same-cycle push.
    always_comb begin
        out_valid = !empty && !iq.branch_mispredict;
        out_inst  = out_valid ? head_entry.inst : '0;
        out_pred  = out_valid ? head_entry.branch_pred : 1'b0;
        write_en  = iq.enq_valid && !full && !iq.branch_mispredict;
`ifdef IQ_BYPASS_EN
        if (empty && iq.enq_valid && !iq.branch_mispredict) begin
            out_valid = 1'b1;
            out_inst  = iq.enq_inst;
            out_pred  = iq.enq_branch_pred;
            write_en  = !iq.deq_ready;
        end
`endif
        pop = out_valid && iq.deq_ready && !empty;

        iq.full            = full;
        iq.almost_full     = (count_q >= AFULL_CNT);
        iq.count           = count_q;
        iq.deq_valid       = out_valid;
        iq.deq_inst        = out_inst;
        iq.deq_branch_pred = out_pred;
    end

    always_ff @(posedge clk) begin
        if (rst || iq.branch_mispredict) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (write_en) tail <= tail + PTR_W'(1);
            if (pop)      head <= head + PTR_W'(1);
            count_q <= count_q + CNT_W'(write_en) - CNT_W'(pop);
        end
    end

    // Storage is never cleared; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (write_en && !rst) begin
            entries[tail] <= {iq.enq_inst, iq.enq_branch_pred};
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed scoreboard bench for inst_queue; follows IQ_BYPASS_EN when it is defined for the build.
module tb_inst_queue;
    import rv32i_types::*;

    localparam int DEPTH = IQ_DEPTH;

    logic clk;
    logic rst;
    int   checks;
    int   fails;
    logic [64:0] sb [$];

    inst_queue_if #(.DEPTH(DEPTH)) iq_bus ();

    inst_queue #(.DEPTH(DEPTH), .AFULL_THR(DEPTH - 2)) dut (
        .clk (clk),
        .rst (rst),
        .iq  (iq_bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] word(input logic [31:0] pc);
        return {pc, pc ^ 32'hA5A5_0013};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the scoreboard, then update the model.
    task automatic apply_stimulus(input logic ev, input logic [31:0] pc, input logic dr, input logic bm);
        logic [64:0] exp_head;
        logic        exp_valid;
        logic        bypass;
        logic        accept;
        iq_bus.enq_valid         = ev;
        iq_bus.enq_inst          = word(pc);
        iq_bus.enq_branch_pred   = pc[2];
        iq_bus.deq_ready         = dr;
        iq_bus.branch_mispredict = bm;
        #1;
        bypass = 1'b0;
`ifdef IQ_BYPASS_EN
        bypass = (sb.size() == 0) && ev && !bm;
`endif
        check_output("full", 64'(iq_bus.full), 64'(sb.size() == DEPTH));
        check_output("almost_full", 64'(iq_bus.almost_full), 64'(sb.size() >= DEPTH - 2));
        check_output("count", 64'(iq_bus.count), 64'(sb.size()));
        exp_valid = ((sb.size() != 0) || bypass) && !bm;
        check_output("deq_valid", 64'(iq_bus.deq_valid), 64'(exp_valid));
        if (exp_valid) begin
            exp_head = bypass ? {word(pc), pc[2]} : sb[0];
            check_output("deq_inst", iq_bus.deq_inst, exp_head[64:1]);
            check_output("deq_branch_pred", 64'(iq_bus.deq_branch_pred), 64'(exp_head[0]));
        end
        accept = ev && (sb.size() != DEPTH) && !bm;
        if (exp_valid && dr && !bypass) void'(sb.pop_front());
        if (accept && !(bypass && dr)) sb.push_back({word(pc), pc[2]});
        if (bm) sb.delete();
        @(posedge clk);
        #1;
        iq_bus.enq_valid         = 1'b0;
        iq_bus.deq_ready         = 1'b0;
        iq_bus.branch_mispredict = 1'b0;
    endtask

    initial begin
        int k;
        checks = 0;
        fails  = 0;
        rst = 1'b1;
        iq_bus.enq_valid         = 1'b0;
        iq_bus.enq_inst          = '0;
        iq_bus.enq_branch_pred   = 1'b0;
        iq_bus.deq_ready         = 1'b0;
        iq_bus.branch_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("rst_count", 64'(iq_bus.count), 64'd0);
        check_output("rst_full", 64'(iq_bus.full), 64'd0);
        check_output("rst_almost_full", 64'(iq_bus.almost_full), 64'd0);
        check_output("rst_deq_valid", 64'(iq_bus.deq_valid), 64'd0);
        check_output("rst_deq_inst", iq_bus.deq_inst, 64'd0);
        check_output("rst_deq_pred", 64'(iq_bus.deq_branch_pred), 64'd0);

        // Three words, dispatch stalled: head is the first pc.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
        check_output("t1_count", 64'(iq_bus.count), 64'd3);
        check_output("t1_valid", 64'(iq_bus.deq_valid), 64'd1);
        check_output("t1_head_pc", 64'(iq_bus.deq_inst[63:32]), 64'h1000);

        // Fill to capacity; almost_full at 14, full at 16, 17th word dropped.
        for (int i = 3; i < 14; i++) apply_stimulus(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
        check_output("t2_afull_14", 64'(iq_bus.almost_full), 64'd1);
        check_output("t2_notfull_14", 64'(iq_bus.full), 64'd0);
        for (int i = 14; i < 16; i++) apply_stimulus(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
        check_output("t2_full", 64'(iq_bus.full), 64'd1);
        apply_stimulus(1'b1, 32'h1040, 1'b0, 1'b0);
        check_output("t2_drop_count", 64'(iq_bus.count), 64'd16);

        // Full with pop and push together: push rejected, accepted on the next cycle.
        apply_stimulus(1'b1, 32'h1040, 1'b1, 1'b0);
        check_output("t3_count_15", 64'(iq_bus.count), 64'd15);
        apply_stimulus(1'b1, 32'h1040, 1'b0, 1'b0);
        check_output("t3_count_16", 64'(iq_bus.count), 64'd16);

        // Drain, then stream 40 words with ready toggling across pointer wrap.
        for (int c = 0; c < 64 && sb.size() != 0; c++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        check_output("t4_drained", 64'(iq_bus.count), 64'd0);
        k = 0;
        for (int c = 0; c < 400 && k < 40; c++) begin
            logic acc;
            acc = (sb.size() != DEPTH);
            apply_stimulus(1'b1, 32'h4000 + 32'(4 * k), (c % 2) == 0, 1'b0);
            if (acc) k++;
        end
        check_output("t4_stream_done", 64'(k), 64'd40);
        for (int c = 0; c < 64 && sb.size() != 0; c++) apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        check_output("t4_empty", 64'(iq_bus.count), 64'd0);

        // Mispredict flush at count 9 with enq and deq both requested.
        for (int i = 0; i < 9; i++) apply_stimulus(1'b1, 32'h5000 + 32'(4 * i), 1'b0, 1'b0);
        check_output("t5_count_9", 64'(iq_bus.count), 64'd9);
        apply_stimulus(1'b1, 32'h5100, 1'b1, 1'b1);
        check_output("t5_flushed", 64'(iq_bus.count), 64'd0);
        check_output("t5_invalid", 64'(iq_bus.deq_valid), 64'd0);
        apply_stimulus(1'b1, 32'h2000, 1'b0, 1'b0);
        check_output("t5_head_valid", 64'(iq_bus.deq_valid), 64'd1);
        check_output("t5_head_pc", 64'(iq_bus.deq_inst[63:32]), 64'h2000);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Enqueue into an empty queue with dispatch ready.
        apply_stimulus(1'b1, 32'h3000, 1'b1, 1'b0);
`ifdef IQ_BYPASS_EN
        check_output("t6_bypass_count", 64'(iq_bus.count), 64'd0);
`else
        check_output("t6_count", 64'(iq_bus.count), 64'd1);
        check_output("t6_next_valid", 64'(iq_bus.deq_valid), 64'd1);
        check_output("t6_next_pc", 64'(iq_bus.deq_inst[63:32]), 64'h3000);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
`endif
        apply_stimulus(1'b1, 32'h3100, 1'b0, 1'b0);
        check_output("t6_stalled_write", 64'(iq_bus.count), 64'd1);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        check_output("t6_final_empty", 64'(iq_bus.count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
